// File: rtl/sprite_motion_ctrl.sv
// Per-frame motion controller for the overlay player box: debounced buttons,
// a slow/fast hold-to-accelerate FSM, screen clamping and frame-aligned position.
module sprite_motion_ctrl #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int OBJ_W       = 50,
    parameter int OBJ_H       = 50,
    parameter int INIT_X      = 40,
    parameter int INIT_Y      = 1,
    parameter int STEP_SLOW   = 1,
    parameter int STEP_FAST   = 4,
    parameter int HOLD_FRAMES = 30
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       vs_n,
    input  logic       btn_up_n,
    input  logic       btn_down_n,
    input  logic       btn_left_n,
    input  logic       btn_right_n,
    input  logic       recenter,
    output logic [9:0] obj_x,
    output logic [9:0] obj_y,
    output logic       frame_tick,
    output logic       moving,
    output logic       fast
);

    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    localparam logic signed [10:0] X_MAX  = 11'(SCREEN_W - OBJ_W);
    localparam logic signed [10:0] Y_MAX  = 11'(SCREEN_H - OBJ_H);
    localparam logic signed [10:0] STEP_S = 11'(STEP_SLOW);
    localparam logic signed [10:0] STEP_F = 11'(STEP_FAST);
    localparam logic [9:0]         CTR_X  = 10'((SCREEN_W - OBJ_W) / 2);
    localparam logic [9:0]         CTR_Y  = 10'((SCREEN_H - OBJ_H) / 2);
    localparam logic [9:0]         RST_X  = 10'(INIT_X);
    localparam logic [9:0]         RST_Y  = 10'(INIT_Y);
    localparam logic [HOLD_W-1:0]  HOLD_MAX = HOLD_W'(HOLD_FRAMES);

    typedef enum logic [1:0] {IDLE, SLOW, FAST} state_t;

    // Button vectors are active-low, bit order {right, left, down, up}.
    logic [3:0]        sync1_q, sync1_d;
    logic [3:0]        sync2_q, sync2_d;
    logic [3:0]        cur_q, cur_d;
    logic [3:0]        prv_q, prv_d;
    logic              vs_hist_q, vs_hist_d;
    logic              frame_tick_q, frame_tick_d;
    logic              recenter_pend_q, recenter_pend_d;
    logic [9:0]        obj_x_q, obj_x_d;
    logic [9:0]        obj_y_q, obj_y_d;
    logic              moving_q, moving_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    state_t            state_q, state_d;

    logic [3:0]         act;
    logic               go_up, go_down, go_left, go_right, any_move;
    logic signed [10:0] step, off_x, off_y, next_x, next_y;
    logic [9:0]         cand_x, cand_y;

    function automatic logic [9:0] clamp_pos(input logic signed [10:0] p,
                                             input logic signed [10:0] hi);
        logic [9:0] r;
        if (p < 11'sd0)
            r = '0;
        else if (p > hi)
            r = hi[9:0];
        else
            r = p[9:0];
        return r;
    endfunction

    always_comb begin
        sync1_d         = {btn_right_n, btn_left_n, btn_down_n, btn_up_n};
        sync2_d         = sync1_q;
        vs_hist_d       = vs_n;
        frame_tick_d    = vs_hist_q & ~vs_n;
        cur_d           = cur_q;
        prv_d           = prv_q;
        recenter_pend_d = recenter_pend_q | recenter;
        obj_x_d         = obj_x_q;
        obj_y_d         = obj_y_q;
        moving_d        = moving_q;
        hold_cnt_d      = hold_cnt_q;
        state_d         = state_q;

        if (frame_tick_q) begin
            cur_d = sync2_q;
            prv_d = cur_q;
        end

        // A direction counts only if pressed in this tick's sample and the last one.
        act      = ~cur_d & ~prv_d;
        go_up    = act[0] & ~act[1];
        go_down  = act[1] & ~act[0];
        go_left  = act[2] & ~act[3];
        go_right = act[3] & ~act[2];
        any_move = go_up | go_down | go_left | go_right;

        step   = (state_q == FAST) ? STEP_F : STEP_S;
        off_x  = go_right ? step : (go_left ? -step : 11'sd0);
        off_y  = go_down  ? step : (go_up   ? -step : 11'sd0);
        next_x = $signed({1'b0, obj_x_q}) + off_x;
        next_y = $signed({1'b0, obj_y_q}) + off_y;
        cand_x = clamp_pos(next_x, X_MAX);
        cand_y = clamp_pos(next_y, Y_MAX);

        if (frame_tick_q) begin
            // A request arriving on the tick itself waits for the next tick.
            recenter_pend_d = recenter;
            if (recenter_pend_q) begin
                obj_x_d    = CTR_X;
                obj_y_d    = CTR_Y;
                state_d    = IDLE;
                hold_cnt_d = '0;
                moving_d   = 1'b1;
            end else if (!any_move) begin
                state_d    = IDLE;
                hold_cnt_d = '0;
                moving_d   = 1'b0;
            end else begin
                obj_x_d  = cand_x;
                obj_y_d  = cand_y;
                moving_d = (cand_x != obj_x_q) || (cand_y != obj_y_q);
                unique case (state_q)
                    IDLE: begin
                        hold_cnt_d = HOLD_W'(1);
                        state_d    = (HOLD_FRAMES <= 1) ? FAST : SLOW;
                    end
                    SLOW: begin
                        if (hold_cnt_q >= HOLD_MAX - HOLD_W'(1)) begin
                            hold_cnt_d = HOLD_MAX;
                            state_d    = FAST;
                        end else begin
                            hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                        end
                    end
                    FAST: state_d = FAST;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            sync1_q         <= '1;
            sync2_q         <= '1;
            cur_q           <= '1;
            prv_q           <= '1;
            vs_hist_q       <= 1'b1;
            frame_tick_q    <= 1'b0;
            recenter_pend_q <= 1'b0;
            obj_x_q         <= RST_X;
            obj_y_q         <= RST_Y;
            moving_q        <= 1'b0;
            hold_cnt_q      <= '0;
            state_q         <= IDLE;
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            cur_q           <= cur_d;
            prv_q           <= prv_d;
            vs_hist_q       <= vs_hist_d;
            frame_tick_q    <= frame_tick_d;
            recenter_pend_q <= recenter_pend_d;
            obj_x_q         <= obj_x_d;
            obj_y_q         <= obj_y_d;
            moving_q        <= moving_d;
            hold_cnt_q      <= hold_cnt_d;
            state_q         <= state_d;
        end
    end

    assign obj_x      = obj_x_q;
    assign obj_y      = obj_y_q;
    assign frame_tick = frame_tick_q;
    assign moving     = moving_q;
    assign fast       = (state_q == FAST);

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: short synthetic frames, hand-computed positions.
module tb_sprite_motion_ctrl;

    logic       vga_clk = 1'b0;
    logic       reset;
    logic       vs_n;
    logic       btn_up_n, btn_down_n, btn_left_n, btn_right_n;
    logic       recenter;
    logic [9:0] obj_x, obj_y;
    logic       frame_tick, moving, fast;

    int checks = 0;
    int errors = 0;
    int tick_cnt = 0;
    int tick_wide = 0;
    logic ft_prev = 1'b0;
    int tick_base, wide_base;

    localparam int S_IDLE = 0;
    localparam int S_SLOW = 1;
    localparam int S_FAST = 2;

    sprite_motion_ctrl dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .vs_n        (vs_n),
        .btn_up_n    (btn_up_n),
        .btn_down_n  (btn_down_n),
        .btn_left_n  (btn_left_n),
        .btn_right_n (btn_right_n),
        .recenter    (recenter),
        .obj_x       (obj_x),
        .obj_y       (obj_y),
        .frame_tick  (frame_tick),
        .moving      (moving),
        .fast        (fast)
    );

    always #5 vga_clk = ~vga_clk;

    always @(negedge vga_clk) begin
        if (frame_tick) begin
            tick_cnt <= tick_cnt + 1;
            if (ft_prev) tick_wide <= tick_wide + 1;
        end
        ft_prev <= frame_tick;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frame();
        repeat (4) @(negedge vga_clk);
        vs_n = 1'b0;
        repeat (3) @(negedge vga_clk);
        vs_n = 1'b1;
        repeat (2) @(negedge vga_clk);
    endtask

    task automatic frame_recenter_on_tick();
        repeat (4) @(negedge vga_clk);
        vs_n = 1'b0;
        @(negedge vga_clk);
        check("rc_tick_high", {31'b0, frame_tick}, 1);
        recenter = 1'b1;
        @(negedge vga_clk);
        recenter = 1'b0;
        @(negedge vga_clk);
        vs_n = 1'b1;
        repeat (2) @(negedge vga_clk);
    endtask

    task automatic pulse_recenter();
        @(negedge vga_clk);
        recenter = 1'b1;
        @(negedge vga_clk);
        recenter = 1'b0;
    endtask

    task automatic check_pos(input string tag, input int ex, input int ey);
        check({tag, "_x"}, {22'b0, obj_x}, ex);
        check({tag, "_y"}, {22'b0, obj_y}, ey);
    endtask

    initial begin
        reset = 1'b1;
        vs_n = 1'b1;
        btn_up_n = 1'b1; btn_down_n = 1'b1; btn_left_n = 1'b1; btn_right_n = 1'b1;
        recenter = 1'b0;
        repeat (3) @(negedge vga_clk);
        check_pos("rst", 40, 1);
        check("rst_tick", {31'b0, frame_tick}, 0);
        check("rst_moving", {31'b0, moving}, 0);
        check("rst_fast", {31'b0, fast}, 0);
        check("rst_state", 32'(dut.state_q), S_IDLE);
        check("rst_hold", 32'(dut.hold_cnt_q), 0);
        reset = 1'b0;

        // Idle frames
        tick_base = tick_cnt;
        wide_base = tick_wide;
        repeat (5) frame();
        check_pos("idle", 40, 1);
        check("idle_moving", {31'b0, moving}, 0);
        check("idle_ticks", 32'(tick_cnt - tick_base), 5);
        check("idle_wide", 32'(tick_wide - wide_base), 0);

        // Debounce: two ticks of press needed
        btn_left_n = 1'b0;
        frame();
        check_pos("deb1", 40, 1);
        check("deb1_state", 32'(dut.state_q), S_IDLE);
        frame();
        check_pos("deb2", 39, 1);
        check("deb2_state", 32'(dut.state_q), S_SLOW);
        check("deb2_moving", {31'b0, moving}, 1);
        btn_left_n = 1'b1;
        frame();
        check_pos("deb_rel", 39, 1);
        check("deb_rel_state", 32'(dut.state_q), S_IDLE);
        check("deb_rel_moving", {31'b0, moving}, 0);
        btn_left_n = 1'b0;
        frame();
        btn_left_n = 1'b1;
        frame();
        check_pos("glitch", 39, 1);
        check("glitch_moving", {31'b0, moving}, 0);

        // Hold-to-accelerate to the right
        @(negedge vga_clk) reset = 1'b1;
        @(negedge vga_clk) reset = 1'b0;
        check_pos("rst2", 40, 1);
        btn_right_n = 1'b0;
        frame();
        check_pos("acc0", 40, 1);
        repeat (29) frame();
        check_pos("acc29", 69, 1);
        check("acc29_fast", {31'b0, fast}, 0);
        check("acc29_hold", 32'(dut.hold_cnt_q), 29);
        frame();
        check_pos("acc30", 70, 1);
        check("acc30_fast", {31'b0, fast}, 1);
        check("acc30_hold", 32'(dut.hold_cnt_q), 30);
        frame();
        check_pos("fast1", 74, 1);
        check("fast1_moving", {31'b0, moving}, 1);

        // Asynchronous reset while holding in FAST
        @(negedge vga_clk) reset = 1'b1;
        #1;
        check_pos("mid_rst", 40, 1);
        check("mid_rst_fast", {31'b0, fast}, 0);
        check("mid_rst_hold", 32'(dut.hold_cnt_q), 0);
        @(negedge vga_clk) reset = 1'b0;
        frame();
        check_pos("post_rst", 40, 1);
        check("post_rst_moving", {31'b0, moving}, 0);
        btn_right_n = 1'b1;
        frame();
        check("post_rst_state", 32'(dut.state_q), S_IDLE);

        // Left wall clamp while FAST
        btn_left_n = 1'b0;
        frame();
        check_pos("lw0", 40, 1);
        repeat (30) frame();
        check_pos("lw30", 10, 1);
        check("lw30_fast", {31'b0, fast}, 1);
        frame();
        check_pos("lw31", 6, 1);
        frame();
        check_pos("lw32", 2, 1);
        frame();
        check_pos("lw_clamp", 0, 1);
        check("lw_clamp_moving", {31'b0, moving}, 1);
        frame();
        check_pos("lw_wall", 0, 1);
        check("lw_wall_moving", {31'b0, moving}, 0);
        check("lw_wall_fast", {31'b0, fast}, 1);
        btn_left_n = 1'b1;
        frame();
        check("lw_rel_state", 32'(dut.state_q), S_IDLE);
        check("lw_rel_fast", {31'b0, fast}, 0);
        check("lw_rel_hold", 32'(dut.hold_cnt_q), 0);

        // Recenter, then opposing vertical buttons with right held
        pulse_recenter();
        frame();
        check_pos("rc1", 295, 215);
        check("rc1_moving", {31'b0, moving}, 1);
        btn_up_n = 1'b0; btn_down_n = 1'b0; btn_right_n = 1'b0;
        frame();
        check_pos("opp0", 295, 215);
        check("opp0_moving", {31'b0, moving}, 0);
        frame();
        check_pos("opp1", 296, 215);
        check("opp1_state", 32'(dut.state_q), S_SLOW);
        frame();
        check_pos("opp2", 297, 215);
        btn_right_n = 1'b1;
        frame();
        check_pos("ud_only", 297, 215);
        check("ud_only_state", 32'(dut.state_q), S_IDLE);
        check("ud_only_moving", {31'b0, moving}, 0);

        // Recenter mid-frame while down is held
        btn_up_n = 1'b1; btn_down_n = 1'b1;
        frame();
        btn_down_n = 1'b0;
        frame();
        check_pos("dn0", 297, 215);
        frame();
        check_pos("dn1", 297, 216);
        pulse_recenter();
        frame();
        check_pos("rc2", 295, 215);
        check("rc2_state", 32'(dut.state_q), S_IDLE);
        check("rc2_moving", {31'b0, moving}, 1);
        frame();
        check_pos("rc2_resume", 295, 216);
        check("rc2_resume_state", 32'(dut.state_q), S_SLOW);

        // Recenter pulse coinciding with frame_tick waits one tick
        frame_recenter_on_tick();
        check_pos("rc_tick_deferred", 295, 217);
        frame();
        check_pos("rc_tick_served", 295, 215);
        check("rc_tick_moving", {31'b0, moving}, 1);

        // Right wall clamp
        btn_down_n = 1'b1;
        frame();
        check_pos("rw_idle", 295, 215);
        check("rw_idle_moving", {31'b0, moving}, 0);
        btn_right_n = 1'b0;
        frame();
        repeat (30) frame();
        check_pos("rw30", 325, 215);
        check("rw30_fast", {31'b0, fast}, 1);
        repeat (66) frame();
        check_pos("rw96", 589, 215);
        frame();
        check_pos("rw_clamp", 590, 215);
        check("rw_clamp_moving", {31'b0, moving}, 1);
        frame();
        check_pos("rw_wall", 590, 215);
        check("rw_wall_moving", {31'b0, moving}, 0);
        btn_right_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
